regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor of the 16x32 CPU register file.
- Generalised data width and depth; optional read-only PC alias at the top address.
- Adds a write-through bypass, a per-register busy scoreboard for pending multi-cycle writebacks (loads), and a sequential clear-on-reset sweep.
- Sits between decode (reads and busy checks) and writeback. Advances only on `pulse_en`, like the rest of the datapath.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W entries.
- PC_ALIAS, 1: 1 = address DEPTH-1 reads `pc` and is never written or marked busy; 0 = ordinary register.
- CLEAR_ON_RESET, 1: 1 = zero every entry after reset; 0 = contents undefined, `init_done` rises one cycle after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pulse_en  in  1  datapath advance strobe; gates writes and scoreboard updates.
- pc  in  DATA_W  program counter, returned on reads of the alias address.
- write  in  1  write `write_data` to `rdest` on the current edge.
- rsrc  in  ADDR_W  source register address.
- rdest  in  ADDR_W  destination register address (read and write).
- write_data  in  DATA_W  writeback data.
- mark_busy  in  1  flag `mark_addr` as awaiting a writeback.
- mark_addr  in  ADDR_W  register to mark busy.
- dsrc  out  DATA_W  source register data.
- ddest  out  DATA_W  destination register data.
- src_busy  out  1  busy bit of `rsrc`.
- dest_busy  out  1  busy bit of `rdest`.
- init_done  out  1  high once the clear sweep has finished.

Behaviour:
- Synchronous, active-high reset:
  - busy vector clears to 0 in one cycle.
  - FSM goes to CLEAR, `clr_idx` = 0, `init_done` = 0.
  - Data outputs are combinational, so they are not reset.
- FSM:
  - CLEAR (CLEAR_ON_RESET=1): every clk, independent of `pulse_en`, write 0 to `mem[clr_idx]` and increment `clr_idx`.
  - After the write at index DEPTH-1, go to RUN. CLEAR therefore lasts exactly DEPTH cycles.
  - RUN: `init_done` = 1 and stays there until the next reset.
  - Reset during CLEAR restarts the sweep at index 0.
  - With CLEAR_ON_RESET=0, CLEAR lasts 1 cycle and writes nothing.
- Ignored during CLEAR: `write` and `mark_busy`. Reads still return the current array contents; no bypass is applied.
- Write (RUN only): `pulse_en && write && !(PC_ALIAS && &rdest)` → `mem[rdest] <= write_data`. A write to the alias address is dropped.
- Reads are combinational, in this priority order:
  1. PC_ALIAS and address all-ones → `pc`.
  2. Else, a write is active this cycle (RUN, `pulse_en`, `write`) to the same address → `write_data` (write-through bypass).
  3. Else → `mem[addr]`.
  - This applies independently to `dsrc`/`rsrc` and `ddest`/`rdest`.
- Scoreboard (RUN only, updated only when `pulse_en`):
  - Set: `mark_busy` sets `busy[mark_addr]`, except for the alias address.
  - Clear: an accepted write clears `busy[rdest]`.
  - Set and clear on the same address in the same cycle → set wins (a new load is issued behind the retiring one).
  - Set and clear on different addresses → both take effect.
- Busy outputs: `src_busy = busy[rsrc]`, `dest_busy = busy[rdest]`. Both are combinational from registered bits and are not bypassed; a clear becomes visible the cycle after the write.
- Alias address: busy always 0.
- Width rules: no arithmetic; the address counter is ADDR_W+1 bits so it does not wrap to 0 prematurely.

Decomposition:
- Package `regfile_pkg`:
  - FSM state enum {CLEAR, RUN}.
  - Default DATA_W/ADDR_W constants.
  - Function `is_alias(addr)`.
- One sub-module `regfile_scoreboard`:
  - Holds the DEPTH-bit busy vector.
  - Inputs: set, set_addr, clr, clr_addr, pulse_en, run.
  - Outputs: two busy lookups.
- Storage array, bypass muxes and FSM stay in `regfile_sb`.

Test Plan:
- Clear sweep: reset high 1 cycle, then low → `init_done` = 0 for 16 cycles and rises on cycle 17. All 16 reads then return 0. Reset asserted at cycle 8 → sweep restarts and again takes 16 cycles.
- Write, read and bypass: in RUN, `pulse_en`=1, `write`=1, `rdest`=3, `write_data`=0xDEADBEEF, `rsrc`=3 → `dsrc` = 0xDEADBEEF in the same cycle. Next cycle with `write`=0 → still 0xDEADBEEF. With `pulse_en`=0 and a write of 0x1 → `mem[3]` unchanged.
- PC alias: `pc`=0x00000100, `rsrc`=15 → `dsrc` = 0x100. Write 0x55 to `rdest`=15 → `ddest` still equals `pc`. `mark_busy` on 15 → `dest_busy` = 0.
- Scoreboard: mark 5 → next cycle `src_busy`=1 with `rsrc`=5. Write to 5 → busy still 1 that cycle, 0 the next. Same-cycle mark 5 and write 5 → busy remains 1.
- Ignored during CLEAR: `write`=1 to `rdest`=2 with 0xAA and `mark_busy` on 2 at cycle 3 of the sweep → after RUN, reg 2 = 0 and `busy[2]` = 0.
- Parameter variant: DATA_W=16, ADDR_W=3, PC_ALIAS=0 → CLEAR takes 8 cycles; address 7 is writable and readable (write 0x1234, read back 0x1234).

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// regfile_pkg : shared types, default widths and alias-address helper
// Rev 1.0
//------------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 4;
   localparam int MAX_ADDR_W = 16;

   // Caller zero-extends the address; only the low addr_w bits are inspected.
   function automatic logic is_alias(input logic [MAX_ADDR_W-1:0] addr,
                                     input int                    addr_w,
                                     input logic                  pc_alias);
      logic all_ones;
      all_ones = 1'b1;
      for (int i = 0; i < MAX_ADDR_W; i++) begin
         if (i < addr_w && !addr[i]) all_ones = 1'b0;
      end
      return pc_alias && all_ones;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
//------------------------------------------------------------------------------
// regfile_scoreboard : per-register busy bits for pending writebacks
// Rev 1.0
//------------------------------------------------------------------------------
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pulse_en,
   input  logic              run,
   input  logic              set,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   output logic              busy_a,
   output logic              busy_b
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] busy;

   // Set is applied after clear so a new load issued behind a retiring one wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
      end else if (run && pulse_en) begin
         if (clr) busy[clr_addr] <= 1'b0;
         if (set) busy[set_addr] <= 1'b1;
      end
   end

   assign busy_a = busy[addr_a];
   assign busy_b = busy[addr_b];

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
//------------------------------------------------------------------------------
// regfile_sb : register file with PC alias, write-through bypass, busy
//              scoreboard and post-reset clear sweep
// Rev 1.0
//------------------------------------------------------------------------------
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int PC_ALIAS       = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pulse_en,
   input  logic [DATA_W-1:0] pc,
   input  logic              write,
   input  logic [ADDR_W-1:0] rsrc,
   input  logic [ADDR_W-1:0] rdest,
   input  logic [DATA_W-1:0] write_data,
   input  logic              mark_busy,
   input  logic [ADDR_W-1:0] mark_addr,
   output logic [DATA_W-1:0] dsrc,
   output logic [DATA_W-1:0] ddest,
   output logic              src_busy,
   output logic              dest_busy,
   output logic              init_done
);

   localparam int              DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);
   localparam logic            ALIAS_EN = (PC_ALIAS != 0);
   localparam logic            CLEAR_EN = (CLEAR_ON_RESET != 0);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W:0]   clr_idx;
   logic [ADDR_W:0]   clr_idx_nx;
   logic              clr_we;
   logic [DATA_W-1:0] mem [DEPTH];

   logic run;
   logic wr_active;
   logic wr_accept;
   logic src_alias;
   logic dest_alias;
   logic mark_alias;

   assign run        = (state == RUN);
   assign src_alias  = is_alias(MAX_ADDR_W'(rsrc),      ADDR_W, ALIAS_EN);
   assign dest_alias = is_alias(MAX_ADDR_W'(rdest),     ADDR_W, ALIAS_EN);
   assign mark_alias = is_alias(MAX_ADDR_W'(mark_addr), ADDR_W, ALIAS_EN);
   assign wr_active  = run && pulse_en && write;
   assign wr_accept  = wr_active && !dest_alias;
   assign init_done  = run;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_nx;
         clr_idx <= clr_idx_nx;
      end
   end

   // The sweep runs on every clock, ignoring pulse_en, so init time is fixed.
   always_comb begin
      state_nx   = state;
      clr_idx_nx = clr_idx;
      clr_we     = 1'b0;
      case (state)
         CLEAR: begin
            if (CLEAR_EN) begin
               clr_we     = 1'b1;
               clr_idx_nx = clr_idx + IDX_ONE;
               if (clr_idx == LAST_IDX) state_nx = RUN;
            end else begin
               state_nx = RUN;
            end
         end
         RUN:     state_nx = RUN;
         default: state_nx = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (clr_we) begin
            mem[clr_idx[ADDR_W-1:0]] <= '0;
         end else if (wr_accept) begin
            mem[rdest] <= write_data;
         end
      end
   end

   always_comb begin
      dsrc = mem[rsrc];
      if (src_alias) begin
         dsrc = pc;
      end else if (wr_active && (rsrc == rdest)) begin
         dsrc = write_data;
      end
   end

   always_comb begin
      ddest = mem[rdest];
      if (dest_alias) begin
         ddest = pc;
      end else if (wr_active) begin
         ddest = write_data;
      end
   end

   regfile_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .pulse_en (pulse_en),
      .run      (run),
      .set      (mark_busy && !mark_alias),
      .set_addr (mark_addr),
      .clr      (wr_accept),
      .clr_addr (rdest),
      .addr_a   (rsrc),
      .addr_b   (rdest),
      .busy_a   (src_busy),
      .busy_b   (dest_busy)
   );

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_regfile_sb : directed self-checking bench for regfile_sb
// Rev 1.0
//------------------------------------------------------------------------------
module tb_regfile_sb;

   logic        clk;
   logic        reset;
   logic        pulse_en;
   logic [31:0] pc;
   logic        write;
   logic [3:0]  rsrc;
   logic [3:0]  rdest;
   logic [31:0] write_data;
   logic        mark_busy;
   logic [3:0]  mark_addr;
   logic [31:0] dsrc;
   logic [31:0] ddest;
   logic        src_busy;
   logic        dest_busy;
   logic        init_done;

   logic        v_pulse_en;
   logic [15:0] v_pc;
   logic        v_write;
   logic [2:0]  v_rsrc;
   logic [2:0]  v_rdest;
   logic [15:0] v_write_data;
   logic        v_mark_busy;
   logic [2:0]  v_mark_addr;
   logic [15:0] v_dsrc;
   logic [15:0] v_ddest;
   logic        v_src_busy;
   logic        v_dest_busy;
   logic        v_init_done;

   int checks;
   int errors;

   regfile_sb dut (
      .clk        (clk),
      .reset      (reset),
      .pulse_en   (pulse_en),
      .pc         (pc),
      .write      (write),
      .rsrc       (rsrc),
      .rdest      (rdest),
      .write_data (write_data),
      .mark_busy  (mark_busy),
      .mark_addr  (mark_addr),
      .dsrc       (dsrc),
      .ddest      (ddest),
      .src_busy   (src_busy),
      .dest_busy  (dest_busy),
      .init_done  (init_done)
   );

   regfile_sb #(
      .DATA_W         (16),
      .ADDR_W         (3),
      .PC_ALIAS       (0),
      .CLEAR_ON_RESET (1)
   ) dut_v (
      .clk        (clk),
      .reset      (reset),
      .pulse_en   (v_pulse_en),
      .pc         (v_pc),
      .write      (v_write),
      .rsrc       (v_rsrc),
      .rdest      (v_rdest),
      .write_data (v_write_data),
      .mark_busy  (v_mark_busy),
      .mark_addr  (v_mark_addr),
      .dsrc       (v_dsrc),
      .ddest      (v_ddest),
      .src_busy   (v_src_busy),
      .dest_busy  (v_dest_busy),
      .init_done  (v_init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after the edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      reset        = 1'b1;
      pulse_en     = 1'b0;
      pc           = 32'h0000_0100;
      write        = 1'b0;
      rsrc         = 4'd0;
      rdest        = 4'd0;
      write_data   = 32'h0;
      mark_busy    = 1'b0;
      mark_addr    = 4'd0;
      v_pulse_en   = 1'b0;
      v_pc         = 16'h0;
      v_write      = 1'b0;
      v_rsrc       = 3'd0;
      v_rdest      = 3'd0;
      v_write_data = 16'h0;
      v_mark_busy  = 1'b0;
      v_mark_addr  = 3'd0;

      tick();
      reset = 1'b0;

      // Sweep: 16 cycles for the default instance, 8 for the variant.
      for (int i = 0; i <= 16; i++) begin
         if (i == 3) begin
            pulse_en   = 1'b1;
            write      = 1'b1;
            rdest      = 4'd2;
            rsrc       = 4'd2;
            write_data = 32'h0000_00AA;
            mark_busy  = 1'b1;
            mark_addr  = 4'd2;
         end else if (i == 4) begin
            write     = 1'b0;
            mark_busy = 1'b0;
         end
         #1;
         check($sformatf("init_done_c%0d", i), 32'(init_done), 32'(i == 16));
         check($sformatf("v_init_done_c%0d", i), 32'(v_init_done), 32'(i >= 8));
         if (i == 3) check("no_bypass_in_clear", dsrc, 32'h0);
         tick();
      end

      rsrc = 4'd2;
      #1;
      check("clear_ignored_reg2", dsrc, 32'h0);
      check("clear_ignored_busy2", 32'(src_busy), 32'h0);
      for (int a = 0; a < 16; a++) begin
         rsrc = 4'(a);
         #1;
         check($sformatf("swept_r%0d", a), dsrc, (a == 15) ? 32'h0000_0100 : 32'h0);
      end

      // Reset in the middle of a sweep restarts it from index 0.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (8) tick();
      #1;
      check("mid_sweep_init", 32'(init_done), 32'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         #1;
         check($sformatf("restart_init_c%0d", i), 32'(init_done), 32'(i == 16));
         tick();
      end

      // Write with same-cycle bypass, then retained value, then pulse_en gating.
      pulse_en   = 1'b1;
      write      = 1'b1;
      rdest      = 4'd3;
      rsrc       = 4'd3;
      write_data = 32'hDEAD_BEEF;
      #1;
      check("bypass_dsrc", dsrc, 32'hDEAD_BEEF);
      check("bypass_ddest", ddest, 32'hDEAD_BEEF);
      tick();
      write = 1'b0;
      #1;
      check("stored_r3", dsrc, 32'hDEAD_BEEF);
      pulse_en   = 1'b0;
      write      = 1'b1;
      write_data = 32'h0000_0001;
      #1;
      check("gated_no_bypass", dsrc, 32'hDEAD_BEEF);
      tick();
      write    = 1'b0;
      pulse_en = 1'b1;
      #1;
      check("gated_no_write", dsrc, 32'hDEAD_BEEF);

      // PC alias at address 15.
      rsrc       = 4'd15;
      rdest      = 4'd15;
      write      = 1'b1;
      write_data = 32'h0000_0055;
      mark_busy  = 1'b1;
      mark_addr  = 4'd15;
      #1;
      check("alias_dsrc", dsrc, 32'h0000_0100);
      check("alias_ddest_on_write", ddest, 32'h0000_0100);
      tick();
      write     = 1'b0;
      mark_busy = 1'b0;
      pc        = 32'h0000_0200;
      #1;
      check("alias_ddest_follows_pc", ddest, 32'h0000_0200);
      check("alias_never_busy", 32'(dest_busy), 32'h0);

      // Scoreboard set, clear, set-wins and independent set/clear.
      mark_busy = 1'b1;
      mark_addr = 4'd5;
      rsrc      = 4'd5;
      rdest     = 4'd0;
      #1;
      check("busy5_before_mark", 32'(src_busy), 32'h0);
      tick();
      mark_busy = 1'b0;
      #1;
      check("busy5_marked", 32'(src_busy), 32'h1);
      write      = 1'b1;
      rdest      = 4'd5;
      write_data = 32'h0000_0077;
      #1;
      check("busy5_during_wb", 32'(src_busy), 32'h1);
      check("dest_busy5_during_wb", 32'(dest_busy), 32'h1);
      tick();
      write = 1'b0;
      #1;
      check("busy5_after_wb", 32'(src_busy), 32'h0);
      check("r5_value", dsrc, 32'h0000_0077);
      write      = 1'b1;
      write_data = 32'h0000_0088;
      mark_busy  = 1'b1;
      mark_addr  = 4'd5;
      tick();
      write     = 1'b0;
      mark_busy = 1'b0;
      #1;
      check("set_wins_same_addr", 32'(src_busy), 32'h1);
      write      = 1'b1;
      rdest      = 4'd5;
      write_data = 32'h0000_0099;
      mark_busy  = 1'b1;
      mark_addr  = 4'd6;
      tick();
      write     = 1'b0;
      mark_busy = 1'b0;
      rdest     = 4'd6;
      #1;
      check("clr_other_addr", 32'(src_busy), 32'h0);
      check("set_other_addr", 32'(dest_busy), 32'h1);
      check("r5_second_wb", dsrc, 32'h0000_0099);
      pulse_en  = 1'b0;
      mark_busy = 1'b1;
      mark_addr = 4'd7;
      tick();
      mark_busy = 1'b0;
      pulse_en  = 1'b1;
      rsrc      = 4'd7;
      #1;
      check("mark_gated_by_pulse", 32'(src_busy), 32'h0);

      // Variant without alias: top address behaves as an ordinary register.
      v_pulse_en   = 1'b1;
      v_write      = 1'b1;
      v_rdest      = 3'd7;
      v_write_data = 16'h1234;
      v_mark_busy  = 1'b1;
      v_mark_addr  = 3'd7;
      tick();
      v_write     = 1'b0;
      v_mark_busy = 1'b0;
      v_rsrc      = 3'd7;
      #1;
      check("v_r7_readback", 32'(v_dsrc), 32'h0000_1234);
      check("v_r7_busy", 32'(v_src_busy), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
